// File: rtl/permuter_lanes_pipe_if.sv
// rtl/permuter_lanes_pipe_if.sv - valid/ready lane-beat bus for the lane permuter
interface permuter_lanes_pipe_if #(
    parameter int LANES = 8,
    parameter int WIDTH = 4,
    localparam int CW = $clog2(LANES)
);
    logic                   in_valid;
    logic                   in_ready;
    logic [LANES*WIDTH-1:0] in_data;
    logic [CW-1:0]          in_ctrl;
    logic                   in_mode;
    logic                   out_valid;
    logic                   out_ready;
    logic [LANES*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_ctrl, in_mode, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, in_mode, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/permuter_lanes_pipe.sv
// rtl/permuter_lanes_pipe.sv - log2(LANES)-stage registered XOR/rotate lane permuter
module permuter_lanes_pipe #(
    parameter int LANES = 8,
    parameter int WIDTH = 4,
    localparam int CW = $clog2(LANES)
) (
    input logic                  clk,
    input logic                  rst_n,
    permuter_lanes_pipe_if.slave bus
);
    localparam int DW = LANES * WIDTH;

    logic [CW-1:0] v;
    logic [CW-1:0] en;
    logic [DW-1:0] d    [CW];
    logic [CW-1:0] c    [CW];
    logic          m    [CW];

    logic          up_v [CW];
    logic [DW-1:0] up_d [CW];
    logic [CW-1:0] up_c [CW];
    logic          up_m [CW];
    logic [DW-1:0] nd   [CW];

    // Stage s moves lanes by distance 2^s; chaining all stages composes to ctrl.
    function automatic logic [DW-1:0] stage_perm(
        input logic [DW-1:0] din,
        input int            s,
        input logic          sel,
        input logic          rot
    );
        logic [DW-1:0] r;
        int            src;
        r = din;
        if (sel) begin
            for (int i = 0; i < LANES; i++) begin
                src = rot ? ((i + (1 << s)) & (LANES - 1)) : (i ^ (1 << s));
                r[i*WIDTH +: WIDTH] = din[src*WIDTH +: WIDTH];
            end
        end
        return r;
    endfunction

    // A stage may load if any stage at or downstream of it is empty, or the sink drains.
    always_comb begin : enable_chain
        logic bubble;
        bubble = 1'b0;
        en     = '0;
        for (int s = CW - 1; s >= 0; s--) begin
            bubble = bubble | ~v[s];
            en[s]  = bubble | bus.out_ready;
        end
    end

    always_comb begin
        up_v[0] = bus.in_valid;
        up_d[0] = bus.in_data;
        up_c[0] = bus.in_ctrl;
        up_m[0] = bus.in_mode;
        for (int s = 1; s < CW; s++) begin
            up_v[s] = v[s-1];
            up_d[s] = d[s-1];
            up_c[s] = c[s-1];
            up_m[s] = m[s-1];
        end
        for (int s = 0; s < CW; s++) begin
            nd[s] = stage_perm(up_d[s], s, up_c[s][s], up_m[s]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < CW; s++) begin
                v[s] <= 1'b0;
                d[s] <= '0;
                c[s] <= '0;
                m[s] <= 1'b0;
            end
        end else begin
            for (int s = 0; s < CW; s++) begin
                if (en[s]) begin
                    v[s] <= up_v[s];
                    d[s] <= nd[s];
                    c[s] <= up_c[s];
                    m[s] <= up_m[s];
                end
            end
        end
    end

    assign bus.in_ready  = en[0];
    assign bus.out_valid = v[CW-1];
    assign bus.out_data  = d[CW-1];
endmodule

// File: tb/tb_permuter_lanes_pipe.sv
// tb/tb_permuter_lanes_pipe.sv - directed and scoreboard bench for permuter_lanes_pipe
module tb_permuter_lanes_pipe;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    permuter_lanes_pipe_if #(.LANES(8), .WIDTH(4)) b8 ();
    permuter_lanes_pipe_if #(.LANES(4), .WIDTH(4)) b4 ();

    permuter_lanes_pipe #(.LANES(8), .WIDTH(4)) dut8 (.clk(clk), .rst_n(rst_n), .bus(b8));
    permuter_lanes_pipe #(.LANES(4), .WIDTH(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic        mode;
        logic [2:0]  ctrl;
        logic [31:0] din;
        logic [31:0] exp;
    } vec8_t;

    typedef struct {
        logic [1:0]  ctrl;
        logic [15:0] din;
        logic [15:0] exp;
    } vec4_t;

    vec8_t tbl8 [8];
    vec4_t tbl4 [4];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model8(input logic [31:0] din, input logic [2:0] ctrl, input logic mode);
        logic [31:0] r;
        int src;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            src = mode ? ((i + int'(ctrl)) % 8) : (i ^ int'(ctrl));
            r[i*4 +: 4] = din[src*4 +: 4];
        end
        return r;
    endfunction

    task automatic send8(input logic mode, input logic [2:0] ctrl, input logic [31:0] din,
                         input logic [31:0] exp, input string name);
        @(negedge clk);
        b8.out_ready = 1'b1;
        b8.in_valid  = 1'b1;
        b8.in_data   = din;
        b8.in_ctrl   = ctrl;
        b8.in_mode   = mode;
        #1 check({name, " in_ready"}, b8.in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        b8.in_valid = 1'b0;
        check({name, " early1"}, b8.out_valid, 0);
        @(negedge clk);
        check({name, " early2"}, b8.out_valid, 0);
        @(negedge clk);
        check({name, " out_valid"}, b8.out_valid, 1);
        check({name, " out_data"}, b8.out_data, exp);
    endtask

    task automatic send4(input logic [1:0] ctrl, input logic [15:0] din,
                         input logic [15:0] exp, input string name);
        @(negedge clk);
        b4.out_ready = 1'b1;
        b4.in_valid  = 1'b1;
        b4.in_data   = din;
        b4.in_ctrl   = ctrl;
        b4.in_mode   = 1'b0;
        @(posedge clk);
        @(negedge clk);
        b4.in_valid = 1'b0;
        check({name, " early1"}, b4.out_valid, 0);
        @(negedge clk);
        check({name, " out_valid"}, b4.out_valid, 1);
        check({name, " out_data"}, b4.out_data, exp);
    endtask

    task automatic run_stream(input int nbeats, input bit rnd, input string tag);
        logic [31:0] bd [32];
        logic [2:0]  bc [32];
        logic        bm [32];
        logic [31:0] q_exp [$];
        logic [31:0] held_d;
        bit held, acc, del;
        int sent, got, cyc, occ, stall_acc;
        sent = 0; got = 0; cyc = 0; occ = 0; stall_acc = 0; held = 0; held_d = '0;
        for (int k = 0; k < nbeats; k++) begin
            bd[k] = $urandom;
            bc[k] = 3'($urandom_range(0, 7));
            bm[k] = 1'($urandom_range(0, 1));
        end
        while (got < nbeats && cyc < 400) begin
            @(negedge clk);
            b8.out_ready = rnd ? 1'($urandom_range(0, 1)) : (cyc >= 6);
            b8.in_valid  = (sent < nbeats);
            if (sent < nbeats) begin
                b8.in_data = bd[sent];
                b8.in_ctrl = bc[sent];
                b8.in_mode = bm[sent];
            end
            #1;
            acc = b8.in_valid & b8.in_ready;
            del = b8.out_valid & b8.out_ready;
            check({tag, " in_ready"}, b8.in_ready, (occ < 3) || b8.out_ready);
            if (held) begin
                check({tag, " stall valid"}, b8.out_valid, 1);
                check({tag, " stall data"}, b8.out_data, held_d);
            end
            if (del) begin
                if (q_exp.size() == 0) check({tag, " extra beat"}, 1, 0);
                else check({tag, " beat data"}, b8.out_data, q_exp.pop_front());
                got++;
            end
            held   = b8.out_valid & !b8.out_ready;
            held_d = b8.out_data;
            if (acc) begin
                q_exp.push_back(model8(bd[sent], bc[sent], bm[sent]));
                sent++;
                if (!rnd && cyc < 6) stall_acc++;
            end
            occ = occ + int'(acc) - int'(del);
            cyc++;
        end
        b8.in_valid  = 1'b0;
        b8.out_ready = 1'b1;
        check({tag, " beats delivered"}, got, nbeats);
        if (!rnd) check({tag, " accepted while stalled"}, stall_acc, 3);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl8[0] = '{1'b0, 3'd0, 32'h76543210, 32'h76543210};
        tbl8[1] = '{1'b0, 3'd3, 32'h76543210, 32'h45670123};
        tbl8[2] = '{1'b0, 3'd7, 32'h76543210, 32'h01234567};
        tbl8[3] = '{1'b1, 3'd3, 32'h76543210, 32'h21076543};
        tbl8[4] = '{1'b1, 3'd5, 32'h76543210, 32'h43210765};
        tbl8[5] = '{1'b1, 3'd0, 32'h76543210, 32'h76543210};
        tbl8[6] = '{1'b1, 3'd1, 32'hFEDCBA98, 32'h8FEDCBA9};
        tbl8[7] = '{1'b0, 3'd5, 32'h76543210, 32'h23016745};
        tbl4[0] = '{2'd0, 16'h3210, 16'h3210};
        tbl4[1] = '{2'd1, 16'h3210, 16'h2301};
        tbl4[2] = '{2'd2, 16'h3210, 16'h1032};
        tbl4[3] = '{2'd3, 16'h3210, 16'h0123};

        b8.in_valid = 1'b0; b8.in_data = '0; b8.in_ctrl = '0; b8.in_mode = 1'b0; b8.out_ready = 1'b0;
        b4.in_valid = 1'b0; b4.in_data = '0; b4.in_ctrl = '0; b4.in_mode = 1'b0; b4.out_ready = 1'b0;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("reset out_valid", b8.out_valid, 0);
        check("reset out_data", b8.out_data, 0);
        check("reset in_ready", b8.in_ready, 1);
        check("reset4 out_valid", b4.out_valid, 0);
        check("reset4 in_ready", b4.in_ready, 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        for (int k = 0; k < 8; k++)
            send8(tbl8[k].mode, tbl8[k].ctrl, tbl8[k].din, tbl8[k].exp, $sformatf("v8[%0d]", k));
        for (int k = 0; k < 4; k++)
            send4(tbl4[k].ctrl, tbl4[k].din, tbl4[k].exp, $sformatf("v4[%0d]", k));

        @(negedge clk);
        run_stream(10, 1'b0, "stall");
        run_stream(24, 1'b1, "random");

        // Fill and stall the pipe, then pulse reset within one low phase.
        @(negedge clk);
        b8.out_ready = 1'b0;
        b8.in_valid  = 1'b1;
        b8.in_data   = 32'hA5A5A5A5;
        b8.in_ctrl   = 3'd2;
        b8.in_mode   = 1'b1;
        repeat (5) @(negedge clk);
        b8.in_valid = 1'b0;
        #1;
        check("full in_ready", b8.in_ready, 0);
        check("full out_valid", b8.out_valid, 1);
        rst_n = 1'b0;
        #1;
        check("midreset out_valid", b8.out_valid, 0);
        check("midreset out_data", b8.out_data, 0);
        check("midreset in_ready", b8.in_ready, 1);
        #1 rst_n = 1'b1;
        b8.out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("post-reset no stale beat", b8.out_valid, 0);
        end
        send8(1'b1, 3'd3, 32'h76543210, 32'h21076543, "post-reset beat");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
